mmp_i2s_tx: RTL and testbench



---
 rtl/mmp_i2s_tx.sv | 96 +++++++++
 tb/tb_mmp_i2s_tx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmp_i2s_tx.sv
// Philips I2S transmitter: divides i_CLK into BCLK/LRCLK and shifts 16-bit stereo pairs MSB-first.
// A one-entry holding buffer feeds each frame load; an empty buffer at a load repeats the last pair.
module mmp_i2s_tx #(
   parameter int BCLK_DIV = 4
) (
   input  logic               i_CLK,
   input  logic               i_RST,
   input  logic               i_VALID,
   input  logic signed [15:0] i_DATA_L,
   input  logic signed [15:0] i_DATA_R,
   input  logic               i_MUTE,
   output logic               o_BCLK,
   output logic               o_LRCLK,
   output logic               o_SDATA,
   output logic               o_FRAME_REQ,
   output logic               o_UNDERRUN
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [4:0]       slot;
   logic [4:0]       slot_nxt;
   logic [31:0]      shift;
   logic [15:0]      hold_l;
   logic [15:0]      hold_r;
   logic             fresh;
   logic             toggle;
   logic             fall;
   logic             load;
   logic [31:0]      src_word;
   logic [31:0]      load_word;

   // Upstream handshake: i_VALID is a push-only strobe with no ready; every
   // strobe is accepted into the holding buffer and overwrites any unsent pair.
   always_comb begin
      toggle    = (div_cnt == DIV_LAST);
      fall      = toggle && o_BCLK;
      slot_nxt  = slot + 5'd1;
      load      = fall && (slot_nxt == 5'd0);
      src_word  = i_VALID ? {i_DATA_L, i_DATA_R} : {hold_l, hold_r};
      load_word = i_MUTE ? 32'h0 : src_word;
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         div_cnt <= '0;
         o_BCLK  <= 1'b0;
      end else begin
         div_cnt <= toggle ? '0 : div_cnt + 1'b1;
         if (toggle) o_BCLK <= ~o_BCLK;
      end
   end

   // Slot, word select and data all advance together on BCLK falling edges.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         slot    <= 5'd31;
         shift   <= 32'h0;
         o_LRCLK <= 1'b0;
         o_SDATA <= 1'b0;
      end else if (fall) begin
         slot    <= slot_nxt;
         o_LRCLK <= (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);
         if (load) begin
            o_SDATA <= load_word[31];
            shift   <= {load_word[30:0], 1'b0};
         end else begin
            o_SDATA <= shift[31];
            shift   <= {shift[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         hold_l      <= 16'h0;
         hold_r      <= 16'h0;
         fresh       <= 1'b0;
         o_FRAME_REQ <= 1'b0;
         o_UNDERRUN  <= 1'b0;
      end else begin
         if (i_VALID) begin
            hold_l <= i_DATA_L;
            hold_r <= i_DATA_R;
         end
         // A strobe coinciding with the load is consumed by the bypass path.
         if (load)         fresh <= 1'b0;
         else if (i_VALID) fresh <= 1'b1;
         o_FRAME_REQ <= load;
         o_UNDERRUN  <= load && !fresh && !i_VALID;
      end
   end

endmodule

// File: tb/tb_mmp_i2s_tx.sv
// Bench for mmp_i2s_tx: reference model predicts each frame word and underrun flag,
// and a negedge monitor reassembles the serial stream on BCLK rises.
module tb_mmp_i2s_tx;

   localparam int D     = 4;
   localparam int FIRST = 2 * D;
   localparam int FRAME = 64 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        mute = 1'b0;
   logic [15:0] dl = 16'h0;
   logic [15:0] dr = 16'h0;
   logic        bclk, lrclk, sdata, frame_req, underrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] exp_q[$];
   logic [0:0]  und_q[$];
   logic [31:0] m_hold = 32'h0;
   logic        m_fresh = 1'b0;
   logic [31:0] m_src;

   logic [31:0] sr = 32'h0;
   int          bitcnt = 0;
   logic        in_frame = 1'b0;
   logic        prev_bclk = 1'b0;
   logic        exp_bclk;
   logic        exp_req;
   logic        exp_lr;
   logic [31:0] e_word;
   logic [0:0]  e_und;

   mmp_i2s_tx #(.BCLK_DIV(D)) dut (
      .i_CLK(clk),
      .i_RST(rst),
      .i_VALID(valid),
      .i_DATA_L(dl),
      .i_DATA_R(dr),
      .i_MUTE(mute),
      .o_BCLK(bclk),
      .o_LRCLK(lrclk),
      .o_SDATA(sdata),
      .o_FRAME_REQ(frame_req),
      .o_UNDERRUN(underrun)
   );

   always #5 clk = ~clk;

   function automatic logic is_load(input int c);
      return (c >= FIRST) && (((c - FIRST) % FRAME) == 0);
   endfunction

   function automatic int next_load(input int c);
      if (c < FIRST) return FIRST;
      return FIRST + (((c - FIRST) / FRAME) + 1) * FRAME;
   endfunction

   // Reference model: cycle count since reset release, holding buffer, frame loads.
   always @(posedge clk) begin
      if (rst) begin
         cyc     = 0;
         m_hold  = 32'h0;
         m_fresh = 1'b0;
      end else begin
         cyc = cyc + 1;
         if (is_load(cyc)) begin
            m_src = valid ? {dl, dr} : m_hold;
            exp_q.push_back(mute ? 32'h0 : m_src);
            und_q.push_back(!m_fresh && !valid);
            m_fresh = 1'b0;
            if (valid) m_hold = {dl, dr};
         end else if (valid) begin
            m_hold  = {dl, dr};
            m_fresh = 1'b1;
         end
      end
   end

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         bitcnt   = 0;
         exp_q.delete();
         und_q.delete();
      end else begin
         exp_bclk = ((cyc / D) % 2) == 1;
         checks++;
         if (bclk !== exp_bclk) begin
            errors++;
            $display("FAIL bclk cyc=%0d got=%b exp=%b", cyc, bclk, exp_bclk);
         end
         exp_req = is_load(cyc);
         checks++;
         if (frame_req !== exp_req) begin
            errors++;
            $display("FAIL frame_req cyc=%0d got=%b exp=%b", cyc, frame_req, exp_req);
         end
         if (exp_req) begin
            if (und_q.size() == 0) begin
               errors++;
               $display("FAIL underrun_queue cyc=%0d got=empty exp=entry", cyc);
            end else begin
               e_und = und_q.pop_front();
               checks++;
               if (underrun !== e_und[0]) begin
                  errors++;
                  $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, e_und[0]);
               end
            end
            if (in_frame) begin
               if (exp_q.size() < 2) begin
                  errors++;
                  $display("FAIL frame_queue cyc=%0d got=%0d exp=2", cyc, exp_q.size());
               end else begin
                  e_word = exp_q.pop_front();
                  checks++;
                  if (bitcnt != 32) begin
                     errors++;
                     $display("FAIL frame_bits cyc=%0d got=%0d exp=32", cyc, bitcnt);
                  end else if (sr !== e_word) begin
                     errors++;
                     $display("FAIL frame_word cyc=%0d got=%h exp=%h", cyc, sr, e_word);
                  end
               end
            end
            in_frame = 1'b1;
            bitcnt   = 0;
         end else begin
            checks++;
            if (underrun !== 1'b0) begin
               errors++;
               $display("FAIL underrun_idle cyc=%0d got=%b exp=0", cyc, underrun);
            end
         end
         if (in_frame && bclk && !prev_bclk && bitcnt < 32) begin
            exp_lr = (bitcnt >= 15) && (bitcnt <= 30);
            checks++;
            if (lrclk !== exp_lr) begin
               errors++;
               $display("FAIL lrclk slot=%0d got=%b exp=%b", bitcnt, lrclk, exp_lr);
            end
            sr     = {sr[30:0], sdata};
            bitcnt = bitcnt + 1;
         end
      end
      prev_bclk = bclk;
   end

   task automatic wait_to_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) begin
         errors++;
         $display("FAIL wait_timeout got_cyc=%0d exp_cyc=%0d", cyc, n);
      end
   endtask

   task automatic strobe(input logic [15:0] l, input logic [15:0] r);
      dl    = l;
      dr    = r;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if ({bclk, lrclk, sdata, frame_req, underrun} !== 5'b0) begin
         errors++;
         $display("FAIL %s got=%b exp=00000", tag, {bclk, lrclk, sdata, frame_req, underrun});
      end
   endtask

   task automatic check_first_load(input string tag);
      wait_to_cyc(FIRST - 1);
      checks++;
      if (frame_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_early_req got=%b exp=0", tag, frame_req);
      end
      @(negedge clk);
      checks++;
      if (frame_req !== 1'b1 || underrun !== 1'b1) begin
         errors++;
         $display("FAIL %s_first_load got=%b%b exp=11", tag, frame_req, underrun);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_values");
      rst = 1'b0;
   endtask

   task automatic test_idle();
      int hi = 0;
      check_first_load("idle");
      repeat (FRAME) begin
         @(negedge clk);
         if (lrclk) hi++;
      end
      checks++;
      if (hi != 16 * 2 * D) begin
         errors++;
         $display("FAIL lrclk_high_cycles got=%0d exp=%0d", hi, 16 * 2 * D);
      end
   endtask

   task automatic test_mid_frame();
      int l = next_load(cyc);
      wait_to_cyc(l + 100);
      strobe(16'h8001, 16'h7FFE);
      wait_to_cyc(next_load(cyc));
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL mid_frame_underrun got=%b exp=0", underrun);
      end
      wait_to_cyc(next_load(cyc));
   endtask

   task automatic test_bypass();
      int l = next_load(cyc);
      wait_to_cyc(l - 1);
      strobe(16'h1234, 16'hABCD);
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL bypass_underrun got=%b exp=0", underrun);
      end
      wait_to_cyc(next_load(cyc));
   endtask

   task automatic test_repeat();
      int und_cnt = 0;
      wait_to_cyc(next_load(cyc) + 40);
      strobe(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      for (int k = 0; k < 4; k++) begin
         wait_to_cyc(next_load(cyc));
         if (k > 0 && underrun === 1'b1) und_cnt++;
      end
      checks++;
      if (und_cnt != 3) begin
         errors++;
         $display("FAIL repeat_underruns got=%0d exp=3", und_cnt);
      end
   endtask

   task automatic test_last_wins_mute();
      int l = next_load(cyc);
      wait_to_cyc(l + 20);
      strobe(16'h00FF, 16'hFF00);
      wait_to_cyc(l + 150);
      strobe(16'h5555, 16'hAAAA);
      wait_to_cyc(next_load(cyc));
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL last_wins_underrun got=%b exp=0", underrun);
      end
      l = next_load(cyc);
      wait_to_cyc(l - 3);
      mute = 1'b1;
      wait_to_cyc(l);
      mute = 1'b0;
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL mute_underrun got=%b exp=1", underrun);
      end
      wait_to_cyc(next_load(cyc));
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         wait_to_cyc(next_load(cyc) + $urandom_range(10, FRAME - 20));
         mute = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0)
            strobe(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      end
      wait_to_cyc(next_load(cyc));
      mute = 1'b0;
      wait_to_cyc(next_load(cyc));
   endtask

   task automatic test_mid_reset();
      int l = next_load(cyc);
      wait_to_cyc(l + 20 * 2 * D + 3);
      rst = 1'b1;
      #1;
      check_outputs_zero("mid_reset_values");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_first_load("after_reset");
      wait_to_cyc(next_load(cyc));
   endtask

   initial begin
      test_reset();
      test_idle();
      test_mid_frame();
      test_bypass();
      test_repeat();
      test_last_wins_mute();
      test_random();
      test_mid_reset();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
